// File: rtl/lcd_write_queue.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_write_queue
//  Purpose  : FIFO-buffered HD44780 write sequencer (setup/pulse/hold/wait).
//  Revision : 1.0
// ============================================================================
module lcd_write_queue #(
    parameter int DEPTH      = 4,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2,
    parameter int HOLD_CYC   = 1,
    parameter int SHORT_WAIT = 40,
    parameter int LONG_WAIT  = 1600
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_rs,
    input  logic [7:0]                   in_data,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [7:0]                   lcd_data,
    output logic                         lcd_enable,
    output logic                         lcd_rw,
    output logic                         lcd_rs
);

    localparam int          c_AW    = $clog2(DEPTH);
    localparam int          c_CW    = $clog2(DEPTH + 1);
    localparam logic [15:0] c_SETUP = 16'(SETUP_CYC);
    localparam logic [15:0] c_PULSE = 16'(PULSE_CYC);
    localparam logic [15:0] c_HOLD  = 16'(HOLD_CYC);
    localparam logic [15:0] c_SHORT = 16'(SHORT_WAIT);
    localparam logic [15:0] c_LONG  = 16'(LONG_WAIT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    // FIFO storage: bit 8 carries rs, bits 7:0 the byte
    logic [8:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [8:0]      w_head;

    state_t          r_state,  w_state_nxt;
    logic [15:0]     r_cnt,    w_cnt_nxt;
    logic            r_en,     w_en_nxt;
    logic [7:0]      r_data,   w_data_nxt;
    logic            r_rs,     w_rs_nxt;
    logic            r_long,   w_long_nxt;
    logic            w_done;
    logic            w_head_long;

    assign w_full   = (r_count == c_CW'(DEPTH));
    assign in_ready = !w_full && !rst;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == ST_IDLE) && (r_count != '0);
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_rs, in_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear (0x01) and home (0x02/0x03) need the long post-write wait
    assign w_head_long = !w_head[8] &&
                         ((w_head[7:0] == 8'h01) || (w_head[7:0] == 8'h02) ||
                          (w_head[7:0] == 8'h03));
    assign w_done      = (r_cnt <= 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_en    <= 1'b0;
            r_data  <= '0;
            r_rs    <= 1'b0;
            r_long  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_en    <= w_en_nxt;
            r_data  <= w_data_nxt;
            r_rs    <= w_rs_nxt;
            r_long  <= w_long_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_en_nxt    = r_en;
        w_data_nxt  = r_data;
        w_rs_nxt    = r_rs;
        w_long_nxt  = r_long;
        case (r_state)
            ST_IDLE: begin
                w_en_nxt = 1'b0;
                if (w_pop) begin
                    w_data_nxt  = w_head[7:0];
                    w_rs_nxt    = w_head[8];
                    w_long_nxt  = w_head_long;
                    w_cnt_nxt   = c_SETUP;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_en_nxt = 1'b0;
                if (w_done) begin
                    w_en_nxt    = 1'b1;
                    w_cnt_nxt   = c_PULSE;
                    w_state_nxt = ST_PULSE;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            ST_PULSE: begin
                if (w_done) begin
                    w_en_nxt    = 1'b0;
                    w_cnt_nxt   = c_HOLD;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            ST_HOLD: begin
                w_en_nxt = 1'b0;
                if (w_done) begin
                    w_cnt_nxt   = r_long ? c_LONG : c_SHORT;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            ST_WAIT: begin
                w_en_nxt = 1'b0;
                if (w_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: begin
                w_en_nxt    = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy       = (r_state != ST_IDLE) || (r_count != '0);
    assign count      = r_count;
    assign lcd_data   = r_data;
    assign lcd_enable = r_en;
    assign lcd_rs     = r_rs;
    assign lcd_rw     = 1'b0;

endmodule
`default_nettype wire
